// File: rtl/ps2_key_receiver_if.sv
// Bundles the PS/2 line inputs and the CPU-facing key port of ps2_key_receiver.
// master is the receiver side, slave is the keyboard/CPU side that drives it.
interface ps2_key_receiver_if;
    logic       PS2_CLK;
    logic       DATA_PS2;
    logic       key_pop;
    logic       key_ready;
    logic [7:0] mem_key;
    logic       key_ext;
    logic       key_break;
    logic       overflow;
    logic       frame_err;

    modport master (
        input  PS2_CLK, DATA_PS2, key_pop,
        output key_ready, mem_key, key_ext, key_break, overflow, frame_err
    );

    modport slave (
        output PS2_CLK, DATA_PS2, key_pop,
        input  key_ready, mem_key, key_ext, key_break, overflow, frame_err
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frames bytes off the PS/2 lines, folds E0/F0 prefixes into
// flags and queues decoded keys in a show-ahead FIFO read by the CPU.
module ps2_key_receiver #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    ps2_key_receiver_if.master  bus
);
    localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, fall, data_bit;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;
    logic                   parity_ok;
    logic [TW-1:0]          to_cnt;
    logic                   timeout;
    logic                   byte_valid, byte_valid_nxt;
    logic                   frame_err, frame_err_nxt;
    logic                   ext_pend, brk_pend;
    logic                   push, push_eff, pop_eff, empty, full, overflow;
    logic [9:0]             push_entry, head;
    logic [9:0]             mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.PS2_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.DATA_PS2};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];
    assign timeout  = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES)) && !fall;

    always_comb begin
        state_nxt      = state;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        if (timeout) begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_bit) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    if (data_bit && parity_ok) byte_valid_nxt = 1'b1;
                    else                       frame_err_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // shift_reg keeps the received byte through the byte_valid cycle for the decoder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            parity_ok <= 1'b0;
            to_cnt    <= '0;
        end else begin
            if (state == IDLE || fall) to_cnt <= '0;
            else if (!timeout)         to_cnt <= to_cnt + TW'(1);
            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {data_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    PARITY:  parity_ok <= ^{shift_reg, data_bit};
                    default: ;
                endcase
            end
        end
    end

    assign push       = byte_valid && (shift_reg != 8'hE0) && (shift_reg != 8'hF0);
    assign push_entry = {ext_pend, brk_pend, shift_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_valid) begin
            case (shift_reg)
                8'hE0:   ext_pend <= 1'b1;
                8'hF0:   brk_pend <= 1'b1;
                default: begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            endcase
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_eff  = bus.key_pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_eff)                 wr_ptr   <= wr_ptr + (AW+1)'(1);
            if (pop_eff)                  rd_ptr   <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop_eff) overflow <= 1'b1;
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.key_ready = !empty;
    assign bus.mem_key   = empty ? 8'h00 : head[7:0];
    assign bus.key_ext   = !empty && head[9];
    assign bus.key_break = !empty && head[8];
    assign bus.overflow  = overflow;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed scenarios plus randomized frames
// compared against a queue-based key model. Clock/timeout scaled down for short runs.
module tb_ps2_key_receiver;
    localparam int CLK_HZ     = 1_000_000;
    localparam int TIMEOUT_US = 200;
    localparam int FIFO_DEPTH = 4;
    localparam int HALF       = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_key_receiver_if bus();

    ps2_key_receiver #(
        .CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US),
        .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int err_seen     = 0;

    logic [9:0] m_q[$];
    bit         m_ext, m_brk, m_ovf;

    always @(negedge clk) if (bus.frame_err === 1'b1) err_seen++;

    // Reference model: keys as {ext,brk,code} in an ordered queue of bounded size.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
            else m_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.DATA_PS2 = bits[i];
            repeat (HALF/2) @(negedge clk);
            bus.PS2_CLK = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.PS2_CLK = 1'b1;
            repeat (HALF/2) @(negedge clk);
        end
        bus.DATA_PS2 = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        send_bits({1'b1, p, b, 1'b0}, 11);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(b, 1'b0);
        model_byte(b);
    endtask

    task automatic do_pop();
        @(negedge clk) bus.key_pop = 1'b1;
        @(negedge clk) bus.key_pop = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.key_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 0", bus.key_ready); end
        tests_run++;
        if (bus.mem_key !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_key: got %h want 00", bus.mem_key); end
        tests_run++;
        if ({bus.key_ext, bus.key_break, bus.overflow, bus.frame_err} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {bus.key_ext, bus.key_break, bus.overflow, bus.frame_err});
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_make();
        send_key(8'h1C);
        tests_run++;
        if ({bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break} !== {1'b1, 8'h1C, 2'b00}) begin
            tests_failed++;
            $display("[TB] FAIL make_1c: got rdy=%b key=%h ext=%b brk=%b want 1 1c 0 0", bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break);
        end
        do_pop();
        tests_run++;
        if ({bus.key_ready, bus.mem_key} !== 9'h000) begin
            tests_failed++;
            $display("[TB] FAIL make_pop: got rdy=%b key=%h want 0 00", bus.key_ready, bus.mem_key);
        end
    endtask

    task automatic test_break();
        send_key(8'hF0);
        send_key(8'h1C);
        tests_run++;
        if ({bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break} !== {1'b1, 8'h1C, 2'b01}) begin
            tests_failed++;
            $display("[TB] FAIL break_1c: got rdy=%b key=%h ext=%b brk=%b want 1 1c 0 1", bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break);
        end
        do_pop();
        tests_run++;
        if (bus.key_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL break_single: got rdy=%b want 0", bus.key_ready); end
    endtask

    task automatic test_ext_break();
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        tests_run++;
        if ({bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break} !== {1'b1, 8'h75, 2'b11}) begin
            tests_failed++;
            $display("[TB] FAIL ext_break_75: got rdy=%b key=%h ext=%b brk=%b want 1 75 1 1", bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break);
        end
        do_pop();
        send_key(8'h1C);
        tests_run++;
        if ({bus.mem_key, bus.key_ext, bus.key_break} !== {8'h1C, 2'b00}) begin
            tests_failed++;
            $display("[TB] FAIL pend_cleared: got key=%h ext=%b brk=%b want 1c 0 0", bus.mem_key, bus.key_ext, bus.key_break);
        end
        do_pop();
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_seen;
        send_frame(8'h1C, 1'b1);
        model_err();
        tests_run++;
        if (err_seen !== e0 + 1) begin tests_failed++; $display("[TB] FAIL parity_err_pulse: got %0d pulses want 1", err_seen - e0); end
        tests_run++;
        if (bus.key_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL parity_no_entry: got rdy=%b want 0", bus.key_ready); end
        send_key(8'h29);
        tests_run++;
        if ({bus.key_ready, bus.mem_key} !== {1'b1, 8'h29}) begin
            tests_failed++;
            $display("[TB] FAIL after_parity_29: got rdy=%b key=%h want 1 29", bus.key_ready, bus.mem_key);
        end
        do_pop();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        foreach (codes[i]) send_key(codes[i]);
        tests_run++;
        if (bus.overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_set: got %b want 1", bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({bus.key_ready, bus.mem_key} !== {1'b1, codes[i]}) begin
                tests_failed++;
                $display("[TB] FAIL overflow_order%0d: got rdy=%b key=%h want 1 %h", i, bus.key_ready, bus.mem_key, codes[i]);
            end
            do_pop();
        end
        tests_run++;
        if (bus.key_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL overflow_drained: got rdy=%b want 0", bus.key_ready); end
        do_pop();
        tests_run++;
        if ({bus.key_ready, bus.mem_key, bus.overflow} !== {1'b0, 8'h00, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL pop_empty: got rdy=%b key=%h ovf=%b want 0 00 1", bus.key_ready, bus.mem_key, bus.overflow);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        send_bits({6'b0, 4'hA, 1'b0}, 5);
        repeat (2 * CLK_HZ / 1_000_000 * TIMEOUT_US) @(negedge clk);
        model_err();
        tests_run++;
        if (err_seen !== e0 + 1) begin tests_failed++; $display("[TB] FAIL timeout_pulse: got %0d pulses want 1", err_seen - e0); end
        tests_run++;
        if (bus.key_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_no_entry: got rdy=%b want 0", bus.key_ready); end
        send_key(8'h5A);
        tests_run++;
        if ({bus.key_ready, bus.mem_key} !== {1'b1, 8'h5A}) begin
            tests_failed++;
            $display("[TB] FAIL after_timeout_5a: got rdy=%b key=%h want 1 5a", bus.key_ready, bus.mem_key);
        end
        do_pop();
    endtask

    task automatic test_midframe_reset();
        send_key(8'h16);
        send_key(8'h1E);
        send_bits({7'b0, 3'b101, 1'b0}, 4);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break, bus.overflow, bus.frame_err} !== 13'h0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_reset: got rdy=%b key=%h ext=%b brk=%b ovf=%b err=%b want all 0",
                     bus.key_ready, bus.mem_key, bus.key_ext, bus.key_break, bus.overflow, bus.frame_err);
        end
        m_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         bad;
        int         e0;
        logic [9:0] exp_head;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hE0 || b == 8'hF0) b = b ^ 8'h01;
                end
            endcase
            bad = ($urandom_range(0, 7) == 0);
            e0  = err_seen;
            send_frame(b, bad);
            if (bad) model_err();
            else     model_byte(b);
            tests_run++;
            if (err_seen !== e0 + int'(bad)) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_err: got %0d pulses want %0d", n, err_seen - e0, int'(bad));
            end
            if ($urandom_range(0, 2) == 0) do_pop();
            exp_head = (m_q.size() != 0) ? m_q[0] : 10'h000;
            tests_run++;
            if ({bus.key_ready, bus.key_ext, bus.key_break, bus.mem_key, bus.overflow} !==
                {m_q.size() != 0, exp_head, m_ovf}) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_head: got rdy=%b ext=%b brk=%b key=%h ovf=%b want %b %b %b %h %b",
                         n, bus.key_ready, bus.key_ext, bus.key_break, bus.mem_key, bus.overflow,
                         m_q.size() != 0, exp_head[9], exp_head[8], exp_head[7:0], m_ovf);
            end
        end
    endtask

    initial begin
        bus.PS2_CLK  = 1'b1;
        bus.DATA_PS2 = 1'b1;
        bus.key_pop  = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        test_reset();
        test_single_make();
        test_break();
        test_ext_break();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_midframe_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
